// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters
// using round-robin arbitration.
// Port 0 is the main pipeline and port 1 is the auxiliary address/branch unit.
//
// A granted operation is latched into the registered alu_* drives. They are
// held for one cycle, or for MULDIV_CYCLES cycles on MUL (1000) and DIV (1010).
// The ALU output is then captured into resp_data, resp_zero and resp_err.
// The result is offered on the owning response port until it is consumed.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   reqN_valid/ready, reqN_a/b/op  request handshake and operands, N = 0,1
//   respN_valid/ready              response handshake, N = 0,1
//   resp_data/zero/err             registered result shared by both ports
//   alu_data1/data2/sel            registered drives to the external ALU
//   alu_result/alu_zero            external ALU outputs
module alu_arbiter #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned WIDTH         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam int unsigned CNT_W  = 4;
  localparam logic [3:0]  OP_MUL = 4'b1000;
  localparam logic [3:0]  OP_DIV = 4'b1010;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             ptr, ptr_nxt;       // preferred requester when both are valid
  logic             id, id_nxt;         // owner of the in-flight operation
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] alu_data1_nxt, alu_data2_nxt, resp_data_nxt;
  logic [3:0]       alu_sel_nxt;
  logic             resp_zero_nxt, resp_err_nxt;
  logic             resp0_valid_nxt, resp1_valid_nxt;

  logic             grant0, grant1, hs0, hs1, resp_hs, div_by_zero;
  logic [3:0]       sel_op;

  // Round-robin grant: a lone requester always wins, otherwise the pointer decides.
  assign grant0 = req0_valid && (!req1_valid || !ptr);
  assign grant1 = req1_valid && (!req0_valid ||  ptr);

  assign req0_ready = (state == IDLE) && grant0 && !reset;
  assign req1_ready = (state == IDLE) && grant1 && !reset;

  assign hs0     = req0_valid && req0_ready;
  assign hs1     = req1_valid && req1_ready;
  assign resp_hs = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
  assign sel_op  = hs1 ? req1_op : req0_op;

  assign div_by_zero = (alu_sel == OP_DIV) && (alu_data2 == '0);

  // Next-state and next-register values.
  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    id_nxt          = id;
    cnt_nxt         = cnt;
    alu_data1_nxt   = alu_data1;
    alu_data2_nxt   = alu_data2;
    alu_sel_nxt     = alu_sel;
    resp_data_nxt   = resp_data;
    resp_zero_nxt   = resp_zero;
    resp_err_nxt    = resp_err;
    resp0_valid_nxt = resp0_valid;
    resp1_valid_nxt = resp1_valid;

    case (state)
      IDLE: begin
        if (hs0 || hs1) begin
          alu_data1_nxt = hs1 ? req1_a : req0_a;
          alu_data2_nxt = hs1 ? req1_b : req0_b;
          alu_sel_nxt   = sel_op;
          id_nxt        = hs1;
          cnt_nxt       = ((sel_op == OP_MUL) || (sel_op == OP_DIV)) ?
                          CNT_W'(MULDIV_CYCLES) : CNT_W'(1);
          state_nxt     = EXEC;
        end
      end
      EXEC: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          // Divide by zero reports an error with an all-ones, non-zero result.
          resp_err_nxt    = div_by_zero;
          resp_data_nxt   = div_by_zero ? '1 : alu_result;
          resp_zero_nxt   = div_by_zero ? 1'b0 : alu_zero;
          resp0_valid_nxt = !id;
          resp1_valid_nxt = id;
          state_nxt       = RESP;
        end
      end
      RESP: begin
        if (resp_hs) begin
          resp0_valid_nxt = 1'b0;
          resp1_valid_nxt = 1'b0;
          ptr_nxt         = !id;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      id          <= 1'b0;
      cnt         <= '0;
      alu_data1   <= '0;
      alu_data2   <= '0;
      alu_sel     <= 4'b0000;
      resp_data   <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      id          <= id_nxt;
      cnt         <= cnt_nxt;
      alu_data1   <= alu_data1_nxt;
      alu_data2   <= alu_data2_nxt;
      alu_sel     <= alu_sel_nxt;
      resp_data   <= resp_data_nxt;
      resp_zero   <= resp_zero_nxt;
      resp_err    <= resp_err_nxt;
      resp0_valid <= resp0_valid_nxt;
      resp1_valid <= resp1_valid_nxt;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter.
// A behavioural ALU model is attached to the alu_* ports.
module tb_alu_arbiter;

  localparam int unsigned W   = 32;
  localparam int unsigned MDC = 4;

  logic         clk, reset;
  logic         req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic         req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] resp_data, alu_data1, alu_data2, alu_result;
  logic         resp_zero, resp_err, alu_zero;
  logic [3:0]   alu_sel;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int          next_pref  = 0;   // requester expected to win a tie

  alu_arbiter #(.MULDIV_CYCLES(MDC), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU; divide by zero yields 0 here so the error override is visible.
  always_comb begin
    case (alu_sel)
      4'b0000: alu_result = alu_data1 & alu_data2;
      4'b0001: alu_result = alu_data1 | alu_data2;
      4'b0010: alu_result = alu_data1 + alu_data2;
      4'b0110: alu_result = alu_data1 - alu_data2;
      4'b0111: alu_result = W'($signed(alu_data1) < $signed(alu_data2));
      4'b1000: alu_result = alu_data1 * alu_data2;
      4'b1010: alu_result = (alu_data2 == '0) ? '0 : alu_data1 / alu_data2;
      4'b1100: alu_result = ~(alu_data1 | alu_data2);
      default: alu_result = alu_data2;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Expected response {err, zero, data} for one operation.
  function automatic logic [W+1:0] model(input logic [3:0] op, input logic [W-1:0] a, b);
    logic [W-1:0] d;
    logic         e;
    e = 1'b0;
    case (op)
      4'b0000: d = a & b;
      4'b0001: d = a | b;
      4'b0010: d = a + b;
      4'b0110: d = a - b;
      4'b0111: d = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b1000: d = a * b;
      4'b1010: begin
        if (b == '0) begin
          e = 1'b1;
          d = '1;
        end else begin
          d = a / b;
        end
      end
      4'b1100: d = ~(a | b);
      default: d = b;
    endcase
    return {e, (!e && d == '0), d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [W-1:0] a, b,
                         input logic [3:0] op);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rvld(input int p);
    return (p == 0) ? resp0_valid : resp1_valid;
  endfunction

  task automatic set_rresp(input int p, input logic v);
    if (p == 0) resp0_ready = v; else resp1_ready = v;
  endtask

  // One transaction on port p, with bp stall cycles before the response is consumed.
  // With other_pending, the other requester stays valid and must wait.
  task automatic do_op(input int p, input logic [W-1:0] a, b, input logic [3:0] op,
                       input int bp, input bit other_pending);
    logic [W+1:0] exp;
    int           lat;
    exp = model(op, a, b);
    lat = (op == 4'b1000 || op == 4'b1010) ? int'(MDC) + 1 : 2;
    set_req(p, 1'b1, a, b, op);
    if (other_pending) set_req(1 - p, 1'b1, W'($urandom), W'($urandom), 4'b0010);
    #1;
    check("req_ready", 64'(rdy(p)), 64'd1);
    check("one_ready", 64'(rdy(1 - p)), 64'd0);
    @(posedge clk); #1;
    set_req(p, 1'b0, W'($urandom), W'($urandom), 4'($urandom));
    for (int i = 1; i < lat; i++) begin
      check("alu_data1_hold", 64'(alu_data1), 64'(a));
      check("alu_data2_hold", 64'(alu_data2), 64'(b));
      check("alu_sel_hold", 64'(alu_sel), 64'(op));
      check("resp_early", 64'(rvld(p)), 64'd0);
      if (other_pending) check("pending_ready_exec", 64'(rdy(1 - p)), 64'd0);
      @(posedge clk); #1;
    end
    check("resp_valid", 64'(rvld(p)), 64'd1);
    check("resp_other", 64'(rvld(1 - p)), 64'd0);
    check("resp_data", 64'(resp_data), 64'(exp[W-1:0]));
    check("resp_zero", 64'(resp_zero), 64'(exp[W]));
    check("resp_err", 64'(resp_err), 64'(exp[W+1]));
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      check("bp_valid", 64'(rvld(p)), 64'd1);
      check("bp_data", 64'(resp_data), 64'(exp[W-1:0]));
      if (other_pending) check("pending_ready_bp", 64'(rdy(1 - p)), 64'd0);
    end
    set_rresp(p, 1'b1);
    #1;
    if (other_pending) check("pending_ready_hs", 64'(rdy(1 - p)), 64'd0);
    @(posedge clk); #1;
    set_rresp(p, 1'b0);
    check("resp_drop", 64'(rvld(p)), 64'd0);
    if (other_pending) check("pending_ready_after", 64'(rdy(1 - p)), 64'd1);
    next_pref = 1 - p;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_resp_data"}, 64'(resp_data), 64'd0);
    check({tag, "_resp_zero"}, 64'(resp_zero), 64'd0);
    check({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    check({tag, "_alu_data1"}, 64'(alu_data1), 64'd0);
    check({tag, "_alu_data2"}, 64'(alu_data2), 64'd0);
    check({tag, "_alu_sel"}, 64'(alu_sel), 64'd0);
    check({tag, "_resp_valid"}, 64'({resp0_valid, resp1_valid}), 64'd0);
    check({tag, "_ready"}, 64'({req0_ready, req1_ready}), 64'd0);
  endtask

  initial begin
    logic [3:0]   ops [10];
    logic [W-1:0] a0, b0, a1, b1;
    int           exp_g, grants, p, bsel;
    logic [3:0]   op;
    logic [W-1:0] ra, rb;

    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
            4'b1000, 4'b1010, 4'b1100, 4'b0011, 4'b1111};
    reset = 1'b1;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_state("reset");
    next_pref = 0;

    // Backpressure with req1 waiting, then req1 MUL, SUB to zero, DIV cases.
    do_op(0, W'(5), W'(7), 4'b0010, 5, 1'b1);
    do_op(1, W'(6), W'(7), 4'b1000, 0, 1'b0);
    do_op(0, W'(9), W'(9), 4'b0110, 0, 1'b0);
    do_op(1, W'(10), W'(0), 4'b1010, 1, 1'b0);
    do_op(0, W'(10), W'(3), 4'b1010, 0, 1'b0);

    // Both requesters continuously valid: grants must alternate every 3 cycles.
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    set_req(0, 1'b1, a0, b0, 4'b0000);
    set_req(1, 1'b1, a1, b1, 4'b0000);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    exp_g  = next_pref;
    grants = 0;
    for (int c = 0; c < 36; c++) begin
      #1;
      check("rr_not_both", 64'(req0_ready && req1_ready), 64'd0);
      if (req0_ready || req1_ready) begin
        check("rr_grant", 64'(req1_ready), 64'(exp_g));
        exp_g = 1 - exp_g;
        grants++;
      end
      if (resp0_valid) check("rr_data0", 64'(resp_data), 64'(a0 & b0));
      if (resp1_valid) check("rr_data1", 64'(resp_data), 64'(a1 & b1));
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    check("rr_grant_count", 64'(grants), 64'd12);
    next_pref = exp_g;

    // Random operations against the model.
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(9)];
      ra = W'($urandom);
      rb = ($urandom_range(3) == 0) ? W'(0) : W'($urandom);
      bsel = int'($urandom_range(3));
      if ($urandom_range(3) == 0) begin
        p = next_pref;
        do_op(p, ra, rb, op, bsel, 1'b1);
        do_op(1 - p, W'($urandom), W'($urandom), ops[$urandom_range(9)], 0, 1'b0);
      end else begin
        do_op(int'($urandom_range(1)), ra, rb, op, bsel, 1'b0);
      end
    end

    // Reset in the middle of a MUL drops it without any response.
    set_req(0, 1'b1, W'(6), W'(7), 4'b1000);
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(1, 1'b1, W'(1), W'(2), 4'b0010);
    #1;
    check("ready_in_reset", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(1, 1'b0, '0, '0, '0);
    #1;
    check_reset_state("midexec");
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("no_resp_after_reset", 64'({resp0_valid, resp1_valid}), 64'd0);
    end
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    next_pref = 0;

    // req1 alone straight after reset is granted immediately.
    do_op(1, W'(3), W'(4), 4'b0001, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters: port 0 is the main pipeline, port 1 is the auxiliary address/branch unit.
- Each requester uses a valid/ready request handshake and a valid/ready response handshake.
- Arbitration is round-robin.
- The block holds ALU operands stable for a programmable number of cycles on MUL/DIV (slow combinational paths), then returns a registered result with a zero flag.

Parameters:
- MULDIV_CYCLES, 4, cycles ALU inputs are held for selector 1000 (MUL) or 1010 (DIV); legal range 1..15.
- WIDTH, 32, operand/result width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  operand A (Data1).
- req0_b  in  WIDTH  operand B (Data2).
- req0_op  in  4  ALU selector code.
- resp0_valid  out  1  result for requester 0 available.
- resp0_ready  in  1  requester 0 consumes the result.
- req1_* / resp1_*  same set as requester 0, for requester 1.
- resp_data  out  WIDTH  registered result, shared by both response ports.
- resp_zero  out  1  registered zero flag of resp_data.
- resp_err  out  1  registered: DIV with operand B == 0.
- alu_data1  out  WIDTH  registered drive to ALU Data1.
- alu_data2  out  WIDTH  registered drive to ALU Data2.
- alu_sel  out  4  registered drive to ALU selector.
- alu_result  in  WIDTH  ALU salida.
- alu_zero  in  1  ALU zflag.

Behaviour:
- Reset values (synchronous, reset high at a clk edge):
  - state = IDLE, priority pointer = 0, exec counter = 0.
  - All req*_ready and resp*_valid = 0.
  - resp_data, resp_zero, resp_err, alu_data1, alu_data2 = 0; alu_sel = 4'b0000.
  - Reset wins over every other event, including mid-EXEC and mid-RESP; the in-flight operation is dropped with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational.
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the priority pointer is granted.
  - reqN_ready = (state == IDLE) && grantN && !reset; never high for both ports.
  - Handshake (valid && ready) at an edge:
    - latch a, b, op into alu_data1/alu_data2/alu_sel;
    - latch granted id;
    - load counter = MULDIV_CYCLES if op is 1000 or 1010, else 1;
    - go to EXEC.
- EXEC:
  - alu_* hold constant; the counter decrements each edge.
  - On the edge where counter == 1:
    - resp_data = alu_result, resp_zero = alu_zero;
    - resp_err = (alu_sel == 1010 && alu_data2 == 0);
    - when resp_err is set, resp_data is forced to all-ones and resp_zero = 0;
    - go to RESP.
- RESP:
  - respN_valid = 1 only for the granted id.
  - resp_data, resp_zero, resp_err stay stable until the handshake.
  - On respN_valid && respN_ready: priority pointer = other id; go to IDLE.
  - A new request cannot be accepted in the same cycle as the response handshake; the earliest acceptance is the next cycle.
- Latency: request handshake in cycle N → resp valid in cycle N+2 for single-cycle ops, N+1+MULDIV_CYCLES for MUL/DIV.
- Throughput: at most one operation per 3 cycles (single-cycle op with resp_ready held high).
- Unknown selector codes are passed through unchanged; the result is whatever the ALU produces (default path returns Data2). Counter = 1.
- Request inputs are sampled only at the handshake edge; later changes have no effect.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- No combinational path from any input to alu_* outputs.

Test Plan:
- Reset then idle: all outputs 0, alu_sel = 0; reset asserted mid-EXEC of a MUL → next cycle state IDLE, no resp*_valid ever asserted.
- req0 ADD (op 0010) a = 5, b = 7 in cycle N → resp0_valid in N+2, resp_data = 12, resp_zero = 0, resp_err = 0; SUB 9−9 → resp_data = 0, resp_zero = 1.
- req1 MUL (op 1000) a = 6, b = 7 with MULDIV_CYCLES = 4 → alu_* stable for 4 cycles, resp1_valid in N+5, resp_data = 42.
- DIV (op 1010) a = 10, b = 0 → resp_err = 1, resp_data = 0xFFFFFFFF, resp_zero = 0; DIV 10/3 → resp_data = 3, resp_err = 0.
- Both requesters valid continuously, AND ops, resp_ready held high → grants 0,1,0,1,... and never both ready in one cycle; req1 alone after reset → granted immediately.
- Backpressure: resp0_ready held low 5 cycles → resp0_valid and resp_data stable; req1 stays pending with req1_ready = 0 until 1 cycle after the response handshake.
